// File: rtl/reflet_timer_bank_pkg.sv
// reflet_timer_bank shared definitions.
// Register offsets, CTRL bit positions and the channel stride.
package reflet_timer_bank_pkg;

   localparam int OFF_CTRL        = 0;
   localparam int OFF_PRESCALE    = 1;
   localparam int OFF_RELOAD_BASE = 2;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_PERIODIC = 1;
   localparam int CTRL_IRQ_EN   = 2;
   localparam int CTRL_PENDING  = 3;

   function automatic int stride(input int cw, input int ws);
      return 2 + 2 * (cw / ws);
   endfunction

endpackage

// File: rtl/reflet_timer_bank_channel.sv
// One timer channel: registers, prescaler, down-counter, COUNT snapshot.
// Addressed by local offset; data_o is 0 when not selected.
module reflet_timer_channel
   import reflet_timer_bank_pkg::*;
#(
   parameter int wordsize      = 8,
   parameter int counter_width = 16,
   parameter int aw            = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sel_i,
   input  logic                we_i,
   input  logic [aw-1:0]       off_i,
   input  logic [wordsize-1:0] data_i,
   output logic [wordsize-1:0] data_o,
   output logic                irq_o
);

   localparam int WS = wordsize;
   localparam int CW = counter_width;
   localparam int B  = CW / WS;
   localparam logic [WS-1:0] PC_ONE  = 1;
   localparam logic [CW-1:0] CNT_ONE = 1;

   logic          en_q, en_d;
   logic          per_q, per_d;
   logic          ie_q, ie_d;
   logic          pend_q, pend_d;
   logic [WS-1:0] pre_q, pre_d;
   logic [WS-1:0] pc_q, pc_d;
   logic [CW-1:0] rld_q, rld_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] cnt_view;

   logic wr, wr_ctrl, wr_pre, rd_cnt0;
   logic tick, expire, start;
   logic [WS-1:0] rd;

   always_comb begin
      wr      = sel_i & we_i;
      wr_ctrl = wr && (off_i == aw'(OFF_CTRL));
      wr_pre  = wr && (off_i == aw'(OFF_PRESCALE));
      rd_cnt0 = sel_i && !we_i && (off_i == aw'(OFF_RELOAD_BASE + B));
      tick    = en_q && (pc_q == pre_q);
      expire  = tick && (cnt_q == '0);
      start   = wr_ctrl && data_i[CTRL_EN] && !en_q;
   end

   always_comb begin
      en_d   = en_q;
      per_d  = per_q;
      ie_d   = ie_q;
      pend_d = pend_q;
      pre_d  = pre_q;
      pc_d   = pc_q;
      rld_d  = rld_q;
      cnt_d  = cnt_q;

      if (en_q)
         pc_d = tick ? '0 : pc_q + PC_ONE;
      if (tick) begin
         if (!expire)
            cnt_d = cnt_q - CNT_ONE;
         else if (per_q)
            cnt_d = rld_q;
      end
      if (expire) begin
         pend_d = 1'b1;
         if (!per_q)
            en_d = 1'b0;
      end
      // a clear racing an expiry loses; written control bits always win
      if (wr_ctrl) begin
         en_d  = data_i[CTRL_EN];
         per_d = data_i[CTRL_PERIODIC];
         ie_d  = data_i[CTRL_IRQ_EN];
         if (data_i[CTRL_PENDING] && !expire)
            pend_d = 1'b0;
      end
      if (start) begin
         cnt_d = rld_q;
         pc_d  = '0;
      end
      if (wr_pre)
         pre_d = data_i;
      for (int i = 0; i < B; i++)
         if (wr && (off_i == aw'(OFF_RELOAD_BASE + i)))
            rld_d[i*WS +: WS] = data_i;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         en_q   <= 1'b0;
         per_q  <= 1'b0;
         ie_q   <= 1'b0;
         pend_q <= 1'b0;
         pre_q  <= '0;
         pc_q   <= '0;
         rld_q  <= '0;
         cnt_q  <= '0;
      end else begin
         en_q   <= en_d;
         per_q  <= per_d;
         ie_q   <= ie_d;
         pend_q <= pend_d;
         pre_q  <= pre_d;
         pc_q   <= pc_d;
         rld_q  <= rld_d;
         cnt_q  <= cnt_d;
      end
   end

   // upper COUNT bytes read back the value frozen by the last byte-0 read
   if (B > 1) begin : g_snap
      logic [CW-WS-1:0] snap_q;
      always_ff @(posedge clk) begin
         if (!reset)
            snap_q <= '0;
         else if (rd_cnt0)
            snap_q <= cnt_q[CW-1:WS];
      end
      assign cnt_view = {snap_q, cnt_q[WS-1:0]};
   end else begin : g_nosnap
      assign cnt_view = cnt_q;
   end

   always_comb begin
      rd = '0;
      if (off_i == aw'(OFF_CTRL))
         rd = WS'({pend_q, ie_q, per_q, en_q});
      if (off_i == aw'(OFF_PRESCALE))
         rd = pre_q;
      for (int i = 0; i < B; i++) begin
         if (off_i == aw'(OFF_RELOAD_BASE + i))
            rd = rld_q[i*WS +: WS];
         if (off_i == aw'(OFF_RELOAD_BASE + B + i))
            rd = cnt_view[i*WS +: WS];
      end
   end

   assign data_o = sel_i ? rd : '0;
   assign irq_o  = pend_q & ie_q;

endmodule

// File: rtl/reflet_timer_bank.sv
// Memory-mapped bank of down-counting timers with per-channel interrupts.
// Decodes the bus window, ORs read data and interrupt lines.
module reflet_timer_bank
   import reflet_timer_bank_pkg::*;
#(
   parameter int wordsize       = 8,
   parameter int base_addr_size = 8,
   parameter int base_addr      = 0,
   parameter int channels       = 2,
   parameter int counter_width  = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [base_addr_size-1:0] addr,
   input  logic [wordsize-1:0]       data_in,
   output logic [wordsize-1:0]       data_out,
   input  logic                      write_en,
   output logic                      interrupt,
   output logic [channels-1:0]       interrupt_vector
);

   localparam int S  = stride(counter_width, wordsize);
   localparam int AW = base_addr_size;

   logic [wordsize-1:0] rd_data [channels];

   for (genvar k = 0; k < channels; k++) begin : g_ch
      localparam logic [AW-1:0] LO = AW'(base_addr + k * S);
      logic [AW:0]   diff;
      logic          hit;

      // borrow bit rejects addresses below this channel's window
      assign diff = {1'b0, addr} - {1'b0, LO};
      assign hit  = enable && !diff[AW] && (diff[AW-1:0] < AW'(S));

      reflet_timer_channel #(
         .wordsize      (wordsize),
         .counter_width (counter_width),
         .aw            (AW)
      ) u_chan (
         .clk    (clk),
         .reset  (reset),
         .sel_i  (hit),
         .we_i   (write_en),
         .off_i  (diff[AW-1:0]),
         .data_i (data_in),
         .data_o (rd_data[k]),
         .irq_o  (interrupt_vector[k])
      );
   end

   always_comb begin
      data_out = '0;
      for (int k = 0; k < channels; k++)
         data_out = data_out | rd_data[k];
   end

   assign interrupt = |interrupt_vector;

endmodule

// File: tb/tb_reflet_timer_bank.sv
// Self-checking bench for reflet_timer_bank.
// Directed scenarios plus randomized runs against a closed-form timer model.
module tb_reflet_timer_bank;

   localparam int CH = 2;
   localparam int S  = 6;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [7:0] addr;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       write_en;
   logic       interrupt;
   logic [1:0] interrupt_vector;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [7:0] rv;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   reflet_timer_bank dut (
      .clk              (clk),
      .reset            (reset),
      .enable           (enable),
      .addr             (addr),
      .data_in          (data_in),
      .data_out         (data_out),
      .write_en         (write_en),
      .interrupt        (interrupt),
      .interrupt_vector (interrupt_vector)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic bus_wr(input int a, input int d);
      @(negedge clk);
      enable   = 1'b1;
      write_en = 1'b1;
      addr     = a[7:0];
      data_in  = d[7:0];
      @(posedge clk);
      #1;
      enable   = 1'b0;
      write_en = 1'b0;
   endtask

   task automatic bus_rd(input int a, output logic [7:0] d);
      @(negedge clk);
      enable   = 1'b1;
      write_en = 1'b0;
      addr     = a[7:0];
      #1 d = data_out;
      @(posedge clk);
      #1 enable = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // t = clock edges since the EN write edge
   function automatic void model(input int p, input int r, input bit per,
                                 input int t, output int cnt,
                                 output bit pend, output bit en);
      int ticks;
      ticks = t / (p + 1);
      if (per) begin
         en   = 1'b1;
         pend = ticks > r;
         cnt  = r - (ticks % (r + 1));
      end else if (ticks <= r) begin
         en   = 1'b1;
         pend = 1'b0;
         cnt  = r - ticks;
      end else begin
         en   = 1'b0;
         pend = 1'b1;
         cnt  = 0;
      end
   endfunction

   task automatic check_all_zero(input string tag);
      for (int a = 0; a < CH * S; a++) begin
         bus_rd(a, rv);
         check($sformatf("%s reg%0d", tag, a), rv, 0);
      end
      check({tag, " irq"}, interrupt, 0);
      check({tag, " ivec"}, interrupt_vector, 0);
   endtask

   initial begin
      int t0, t, cnt, p, r, ch, steps, act, snap;
      bit per, ie, pend, en, snap_ok;

      reset    = 1'b0;
      enable   = 1'b0;
      write_en = 1'b0;
      addr     = '0;
      data_in  = '0;
      tick(3);
      reset = 1'b1;
      check_all_zero("rst");

      // one-shot expiry on ch0
      bus_wr(1, 3);
      bus_wr(2, 4);
      bus_wr(3, 0);
      bus_wr(0, 8'h05);
      t0 = cyc;
      tick(19);
      check("os ivec@19", interrupt_vector[0], 0);
      tick(1);
      check("os ivec@20", interrupt_vector[0], 1);
      check("os irq@20", interrupt, 1);
      bus_rd(4, rv);
      check("os cnt0", rv, 0);
      bus_rd(5, rv);
      check("os cnt1", rv, 0);
      bus_rd(0, rv);
      check("os ctrl", rv, 8'h0C);
      bus_wr(0, 8'h08);
      check("os clr", interrupt, 0);

      // periodic ch1, clear between and at expiry
      bus_wr(7, 0);
      bus_wr(8, 9);
      bus_wr(9, 0);
      bus_wr(6, 8'h07);
      t0 = cyc;
      tick(10);
      check("per irq@10", interrupt, 1);
      bus_wr(6, 8'h0F);
      check("per clr@11", interrupt, 0);
      tick(8);
      check("per irq@19", interrupt, 0);
      tick(1);
      check("per irq@20", interrupt, 1);
      tick(9);
      bus_wr(6, 8'h0F);
      check("race irq@30", interrupt, 1);
      check("race ivec", interrupt_vector, 2'b10);
      bus_rd(6, rv);
      check("race ctrl", rv, 8'h0F);
      bus_wr(6, 8'h0F);
      check("race clr", interrupt, 0);
      bus_wr(6, 0);
      bus_wr(6, 8'h08);

      // atomic COUNT snapshot
      bus_wr(1, 0);
      bus_wr(2, 8'h00);
      bus_wr(3, 8'h01);
      bus_wr(0, 8'h01);
      t0 = cyc;
      bus_rd(4, rv);
      check("snap b0", rv, 8'h00);
      tick(3);
      bus_rd(5, rv);
      check("snap b1", rv, 8'h01);
      t = cyc - 1 - t0;
      bus_rd(4, rv);
      t = cyc - 1 - t0;
      check("snap live b0", rv, (256 - t) & 8'hFF);
      bus_rd(5, rv);
      check("snap b1 new", rv, 8'h00);

      // reset mid-count with both channels running
      bus_wr(6, 8'h07);
      tick(4);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("mid rst irq", interrupt, 0);
      check("mid rst ivec", interrupt_vector, 0);
      check_all_zero("mid rst");
      reset = 1'b1;
      tick(30);
      check("post rst irq", interrupt, 0);
      check_all_zero("post rst");

      // out-of-span and disabled accesses
      bus_rd(CH * S, rv);
      check("oos rd12", rv, 0);
      bus_rd(255, rv);
      check("oos rd255", rv, 0);
      bus_wr(CH * S, 8'hFF);
      bus_wr(CH * S + 1, 8'hFF);
      @(negedge clk);
      enable   = 1'b0;
      write_en = 1'b1;
      addr     = 8'd0;
      data_in  = 8'h07;
      #1 check("dis dout", data_out, 0);
      @(posedge clk);
      addr = 8'd1;
      @(posedge clk);
      #1 write_en = 1'b0;
      check_all_zero("oos");

      // randomized runs
      for (int trial = 0; trial < 30; trial++) begin
         for (int k = 0; k < CH; k++) begin
            bus_wr(k * S, 0);
            bus_wr(k * S, 8'h08);
         end
         ch  = $urandom_range(0, CH - 1);
         per = 1'($urandom);
         ie  = 1'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            p = 0;
            r = 256 + $urandom_range(0, 4);
         end else begin
            p = $urandom_range(0, 3);
            r = $urandom_range(0, 12);
         end
         bus_wr(ch * S + 1, p);
         bus_wr(ch * S + 2, r & 8'hFF);
         bus_wr(ch * S + 3, r >> 8);
         bus_wr(ch * S, 1 | (32'(per) << 1) | (32'(ie) << 2));
         t0      = cyc;
         snap_ok = 1'b0;
         snap    = 0;
         steps   = $urandom_range(10, 60);
         for (int s = 0; s < steps; s++) begin
            act = $urandom_range(0, 4);
            if (act == 2 && !snap_ok)
               act = 1;
            case (act)
               0: begin
                  bus_rd(ch * S, rv);
                  model(p, r, per, cyc - 1 - t0, cnt, pend, en);
                  check($sformatf("rnd%0d ctrl", trial), rv,
                        {pend, ie, per, en});
               end
               1: begin
                  bus_rd(ch * S + 4, rv);
                  model(p, r, per, cyc - 1 - t0, cnt, pend, en);
                  check($sformatf("rnd%0d cnt0", trial), rv, cnt & 8'hFF);
                  snap    = cnt >> 8;
                  snap_ok = 1'b1;
               end
               2: begin
                  bus_rd(ch * S + 5, rv);
                  check($sformatf("rnd%0d cnt1", trial), rv, snap);
               end
               3: bus_wr(ch * S + 4 + $urandom_range(0, 1), $urandom);
               default: tick(1);
            endcase
            model(p, r, per, cyc - t0, cnt, pend, en);
            check($sformatf("rnd%0d ivec", trial), interrupt_vector,
                  2'(pend & ie) << ch);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
